// File: rtl/vadd_float_ctrl_pkg.sv
// rtl/vadd_float_ctrl_pkg.sv - register map, CTRL bit positions and FSM state types for vadd_float_ctrl_regs
package vadd_float_ctrl_pkg;

    localparam logic [5:0] ADDR_CTRL    = 6'h00;
    localparam logic [5:0] ADDR_GIE     = 6'h04;
    localparam logic [5:0] ADDR_IER     = 6'h08;
    localparam logic [5:0] ADDR_ISR     = 6'h0C;
    localparam logic [5:0] ADDR_SCALAR  = 6'h10;
    localparam logic [5:0] ADDR_PTR_LO  = 6'h18;
    localparam logic [5:0] ADDR_PTR_HI  = 6'h1C;

    localparam int CTRL_AP_START     = 0;
    localparam int CTRL_AP_DONE      = 1;
    localparam int CTRL_AP_IDLE      = 2;
    localparam int CTRL_AP_READY     = 3;
    localparam int CTRL_AUTO_RESTART = 7;

    localparam int ISR_DONE  = 0;
    localparam int ISR_READY = 1;

    // WRRESET/RDRESET hold the ready outputs low for the cycle reset is released
    typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rd_state_t;

    // Byte-lane merge of a write beat into an existing 32-bit register
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/vadd_float_ctrl_regs.sv
// rtl/vadd_float_ctrl_regs.sv - AXI4-Lite control slave driving the vadd_float kernel start/arguments
module vadd_float_ctrl_regs
    import vadd_float_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_control_awvalid,
    output logic                            s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                            s_axi_control_wvalid,
    output logic                            s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                            s_axi_control_bvalid,
    input  logic                            s_axi_control_bready,
    output logic [1:0]                      s_axi_control_bresp,
    input  logic                            s_axi_control_arvalid,
    output logic                            s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                            s_axi_control_rvalid,
    input  logic                            s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                      s_axi_control_rresp,
    output logic                            interrupt,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    input  logic                            ap_ready,
    output logic [31:0]                     scalar00,
    output logic [63:0]                     axi00_ptr0
);

    wr_state_t   r_wstate;
    rd_state_t   r_rstate;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [5:0]  r_waddr;

    logic        r_ap_start;
    logic        r_auto_restart;
    logic        r_done;
    logic        r_gie;
    logic [1:0]  r_ier;
    logic [1:0]  r_isr;
    logic [31:0] r_scalar;
    logic [31:0] r_ptr_lo;
    logic [31:0] r_ptr_hi;

    logic        w_wr_hs;
    logic        w_ar_hs;
    logic [5:0]  w_raddr;
    logic        w_wr_ctrl;
    logic        w_wr_gie;
    logic        w_wr_ier;
    logic        w_wr_isr;
    logic        w_wr_scalar;
    logic        w_wr_ptr_lo;
    logic        w_wr_ptr_hi;
    logic [1:0]  w_isr_tog;
    logic [1:0]  w_isr_set;
    logic [31:0] w_ctrl;
    logic [31:0] w_rdata;
    logic        w_unused_addr_lsbs;

    // Word-aligned decode; the two byte-offset bits carry no meaning
    assign w_unused_addr_lsbs = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

    assign w_wr_hs     = r_wready & s_axi_control_wvalid;
    assign w_ar_hs     = r_arready & s_axi_control_arvalid;
    assign w_raddr     = {s_axi_control_araddr[5:2], 2'b00};
    assign w_wr_ctrl   = w_wr_hs && (r_waddr == ADDR_CTRL);
    assign w_wr_gie    = w_wr_hs && (r_waddr == ADDR_GIE);
    assign w_wr_ier    = w_wr_hs && (r_waddr == ADDR_IER);
    assign w_wr_isr    = w_wr_hs && (r_waddr == ADDR_ISR);
    assign w_wr_scalar = w_wr_hs && (r_waddr == ADDR_SCALAR);
    assign w_wr_ptr_lo = w_wr_hs && (r_waddr == ADDR_PTR_LO);
    assign w_wr_ptr_hi = w_wr_hs && (r_waddr == ADDR_PTR_HI);

    // Kernel events are latched only when enabled; a same-cycle set overrides the host toggle
    assign w_isr_tog = (w_wr_isr && s_axi_control_wstrb[0]) ? s_axi_control_wdata[1:0] : 2'b00;
    assign w_isr_set = {ap_ready & r_ier[ISR_READY], ap_done & r_ier[ISR_DONE]};

    // Write channel FSM: address phase, data phase, response phase
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_wstate  <= WRRESET;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_waddr   <= '0;
        end else begin
            case (r_wstate)
                WRRESET: begin
                    r_wstate  <= WRIDLE;
                    r_awready <= 1'b1;
                end
                WRIDLE: begin
                    if (s_axi_control_awvalid && r_awready) begin
                        r_waddr   <= {s_axi_control_awaddr[5:2], 2'b00};
                        r_wstate  <= WRDATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end
                end
                WRDATA: begin
                    if (w_wr_hs) begin
                        r_wstate <= WRRESP;
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                    end
                end
                WRRESP: begin
                    if (s_axi_control_bready) begin
                        r_wstate  <= WRIDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= WRIDLE;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // CTRL view: done comes from the latch, idle/ready are the live kernel inputs
    always_comb begin
        w_ctrl                    = '0;
        w_ctrl[CTRL_AP_START]     = r_ap_start;
        w_ctrl[CTRL_AP_DONE]      = r_done;
        w_ctrl[CTRL_AP_IDLE]      = ap_idle;
        w_ctrl[CTRL_AP_READY]     = ap_ready;
        w_ctrl[CTRL_AUTO_RESTART] = r_auto_restart;
    end

    // Read data mux; unmapped offsets read as zero
    always_comb begin
        w_rdata = '0;
        case (w_raddr)
            ADDR_CTRL:   w_rdata = w_ctrl;
            ADDR_GIE:    w_rdata = {31'b0, r_gie};
            ADDR_IER:    w_rdata = {30'b0, r_ier};
            ADDR_ISR:    w_rdata = {30'b0, r_isr};
            ADDR_SCALAR: w_rdata = r_scalar;
            ADDR_PTR_LO: w_rdata = r_ptr_lo;
            ADDR_PTR_HI: w_rdata = r_ptr_hi;
            default:     w_rdata = '0;
        endcase
    end

    // Read channel FSM: capture data at the AR handshake and hold it until accepted
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_rstate  <= RDRESET;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                RDRESET: begin
                    r_rstate  <= RDIDLE;
                    r_arready <= 1'b1;
                end
                RDIDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_rdata;
                        r_rstate  <= RDDATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                    end
                end
                RDDATA: begin
                    if (s_axi_control_rready) begin
                        r_rstate  <= RDIDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= RDIDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Control/status state: start handshake, done latch, interrupt enables and status
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_ap_start     <= 1'b0;
            r_auto_restart <= 1'b0;
            r_done         <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= '0;
            r_isr          <= '0;
        end else begin
            if (w_wr_ctrl && s_axi_control_wstrb[0]) begin
                r_auto_restart <= s_axi_control_wdata[CTRL_AUTO_RESTART];
            end
            // Host can only set start; the kernel's ready pulse retires it
            if (w_wr_ctrl && s_axi_control_wstrb[0] && s_axi_control_wdata[CTRL_AP_START]) begin
                r_ap_start <= 1'b1;
            end else if (ap_ready && !r_auto_restart) begin
                r_ap_start <= 1'b0;
            end
            if (ap_done) begin
                r_done <= 1'b1;
            end else if (w_ar_hs && (w_raddr == ADDR_CTRL)) begin
                r_done <= 1'b0;
            end
            if (w_wr_gie && s_axi_control_wstrb[0]) r_gie <= s_axi_control_wdata[0];
            if (w_wr_ier && s_axi_control_wstrb[0]) r_ier <= s_axi_control_wdata[1:0];
            r_isr <= (r_isr ^ w_isr_tog) | w_isr_set;
        end
    end

    // Kernel argument registers, byte-writable
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_scalar <= '0;
            r_ptr_lo <= '0;
            r_ptr_hi <= '0;
        end else begin
            if (w_wr_scalar) r_scalar <= byte_merge(r_scalar, s_axi_control_wdata, s_axi_control_wstrb);
            if (w_wr_ptr_lo) r_ptr_lo <= byte_merge(r_ptr_lo, s_axi_control_wdata, s_axi_control_wstrb);
            if (w_wr_ptr_hi) r_ptr_hi <= byte_merge(r_ptr_hi, s_axi_control_wdata, s_axi_control_wstrb);
        end
    end

    assign s_axi_control_awready = r_awready;
    assign s_axi_control_wready  = r_wready;
    assign s_axi_control_bvalid  = r_bvalid;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = r_arready;
    assign s_axi_control_rvalid  = r_rvalid;
    assign s_axi_control_rdata   = r_rdata;
    assign s_axi_control_rresp   = 2'b00;
    assign interrupt             = r_gie & (|r_isr);
    assign ap_start              = r_ap_start;
    assign scalar00              = r_scalar;
    assign axi00_ptr0            = {r_ptr_hi, r_ptr_lo};

endmodule

// File: tb/tb_vadd_float_ctrl_regs.sv
// tb/tb_vadd_float_ctrl_regs.sv - scoreboard bench for vadd_float_ctrl_regs
module tb_vadd_float_ctrl_regs;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [5:0]  awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [5:0]  araddr = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        irq;
    logic        ap_start;
    logic        ap_done = 1'b0;
    logic        ap_idle = 1'b0;
    logic        ap_ready = 1'b0;
    logic [31:0] scalar00;
    logic [63:0] axi00_ptr0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rq[$];
    logic [1:0]  bq[$];

    vadd_float_ctrl_regs dut (
        .ap_clk                (ap_clk),
        .areset                (areset),
        .s_axi_control_awvalid (awvalid),
        .s_axi_control_awready (awready),
        .s_axi_control_awaddr  (awaddr),
        .s_axi_control_wvalid  (wvalid),
        .s_axi_control_wready  (wready),
        .s_axi_control_wdata   (wdata),
        .s_axi_control_wstrb   (wstrb),
        .s_axi_control_bvalid  (bvalid),
        .s_axi_control_bready  (bready),
        .s_axi_control_bresp   (bresp),
        .s_axi_control_arvalid (arvalid),
        .s_axi_control_arready (arready),
        .s_axi_control_araddr  (araddr),
        .s_axi_control_rvalid  (rvalid),
        .s_axi_control_rready  (rready),
        .s_axi_control_rdata   (rdata),
        .s_axi_control_rresp   (rresp),
        .interrupt             (irq),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .ap_idle               (ap_idle),
        .ap_ready              (ap_ready),
        .scalar00              (scalar00),
        .axi00_ptr0            (axi00_ptr0)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    // Monitor: pops the expected response whenever a response handshake is about to occur
    always @(negedge ap_clk) begin
        logic [31:0] e;
        logic [1:0]  eb;
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rdata_unexpected: got 0x%0h with no expected read", rdata);
            end else begin
                e = rq.pop_front();
                check("rdata", {32'b0, rdata}, {32'b0, e});
                check("rresp", {62'b0, rresp}, 64'd0);
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL bresp_unexpected: got 0x%0h with no expected write", bresp);
            end else begin
                eb = bq.pop_front();
                check("bresp", {62'b0, bresp}, {62'b0, eb});
            end
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic pulse_done);
        int t;
        bq.push_back(2'b00);
        @(posedge ap_clk); #1;
        awvalid = 1'b1; awaddr = a;
        t = 0;
        do begin @(negedge ap_clk); t++; end while (!awready && t < 50);
        if (!awready) timeout_fail("aw_wait");
        @(posedge ap_clk); #1;
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = d; wstrb = s; ap_done = pulse_done;
        t = 0;
        do begin @(negedge ap_clk); t++; end while (!wready && t < 50);
        if (!wready) timeout_fail("w_wait");
        @(posedge ap_clk); #1;
        wvalid = 1'b0; ap_done = 1'b0;
        t = 0;
        do begin @(negedge ap_clk); t++; end while (!(bvalid && bready) && t < 50);
        if (!bvalid) timeout_fail("b_wait");
        @(posedge ap_clk); #1;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] e);
        int t;
        rq.push_back(e);
        @(posedge ap_clk); #1;
        arvalid = 1'b1; araddr = a;
        t = 0;
        do begin @(negedge ap_clk); t++; end while (!arready && t < 50);
        if (!arready) timeout_fail("ar_wait");
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        check("rvalid_latency", {63'b0, rvalid}, 64'd1);
        t = 0;
        while (!rvalid && t < 50) begin @(negedge ap_clk); t++; end
        @(negedge ap_clk);
        @(posedge ap_clk); #1;
    endtask

    task automatic pulse(input logic p_ready, input logic p_done);
        @(posedge ap_clk); #1;
        ap_ready = p_ready; ap_done = p_done;
        @(posedge ap_clk); #1;
        ap_ready = 1'b0; ap_done = 1'b0;
    endtask

    initial begin
        int t;
        logic ok;

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_ready", {59'b0, awready, wready, bvalid, arready, rvalid}, 64'd0);
        check("rst_irq_start", {62'b0, irq, ap_start}, 64'd0);
        check("rst_scalar", {32'b0, scalar00}, 64'd0);
        check("rst_ptr", axi00_ptr0, 64'd0);
        @(posedge ap_clk); #1;
        areset = 1'b0;

        // Argument registers
        axi_write(6'h10, 32'h12345678, 4'hF, 1'b0);
        axi_write(6'h18, 32'hDEADBEEF, 4'hF, 1'b0);
        axi_write(6'h1C, 32'h00000001, 4'hF, 1'b0);
        check("scalar_full", {32'b0, scalar00}, 64'h12345678);
        check("ptr_full", axi00_ptr0, 64'h00000001_DEADBEEF);
        axi_read(6'h10, 32'h12345678);
        axi_read(6'h18, 32'hDEADBEEF);
        axi_read(6'h1C, 32'h00000001);
        axi_write(6'h10, 32'hAABBCCDD, 4'b0010, 1'b0);
        check("scalar_strb", {32'b0, scalar00}, 64'h1234CC78);
        axi_read(6'h10, 32'h1234CC78);

        // Start / done / ready handshake
        ap_idle = 1'b1;
        axi_write(6'h00, 32'h1, 4'hF, 1'b0);
        check("start_set", {63'b0, ap_start}, 64'd1);
        @(posedge ap_clk); #1;
        ap_ready = 1'b1; ap_done = 1'b1;
        @(negedge ap_clk);
        check("start_hold_in_ready_cycle", {63'b0, ap_start}, 64'd1);
        @(posedge ap_clk); #1;
        ap_ready = 1'b0; ap_done = 1'b0;
        check("start_fall", {63'b0, ap_start}, 64'd0);
        axi_read(6'h00, 32'h6);
        axi_read(6'h00, 32'h4);

        // Auto restart keeps start high through ready
        axi_write(6'h00, 32'h81, 4'hF, 1'b0);
        pulse(1'b1, 1'b0);
        check("auto_restart_hold", {63'b0, ap_start}, 64'd1);
        axi_read(6'h00, 32'h85);
        axi_write(6'h00, 32'h0, 4'hF, 1'b0);
        check("write0_no_clear", {63'b0, ap_start}, 64'd1);
        pulse(1'b1, 1'b0);
        check("start_fall_after_auto", {63'b0, ap_start}, 64'd0);

        // Interrupt path
        axi_write(6'h04, 32'h1, 4'hF, 1'b0);
        axi_write(6'h08, 32'h1, 4'hF, 1'b0);
        check("irq_idle", {63'b0, irq}, 64'd0);
        pulse(1'b0, 1'b1);
        check("irq_on_done", {63'b0, irq}, 64'd1);
        axi_write(6'h0C, 32'h1, 4'hF, 1'b0);
        check("irq_cleared", {63'b0, irq}, 64'd0);
        pulse(1'b0, 1'b1);
        axi_write(6'h0C, 32'h1, 4'hF, 1'b1);
        check("irq_set_beats_toggle", {63'b0, irq}, 64'd1);
        axi_read(6'h0C, 32'h1);

        // W before AW, held-off response, unmapped access
        bready = 1'b0;
        bq.push_back(2'b00);
        @(posedge ap_clk); #1;
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
        ok = 1'b1;
        repeat (3) begin @(negedge ap_clk); if (wready) ok = 1'b0; end
        check("wready_held_off", {63'b0, ok}, 64'd1);
        @(posedge ap_clk); #1;
        awvalid = 1'b1; awaddr = 6'h24;
        t = 0;
        do begin @(negedge ap_clk); t++; end while (!awready && t < 50);
        if (!awready) timeout_fail("aw_wait_wfirst");
        @(posedge ap_clk); #1;
        awvalid = 1'b0;
        t = 0;
        do begin @(negedge ap_clk); t++; end while (!wready && t < 50);
        if (!wready) timeout_fail("w_wait_wfirst");
        @(posedge ap_clk); #1;
        wvalid = 1'b0;
        ok = 1'b1;
        repeat (5) begin @(negedge ap_clk); if (!bvalid) ok = 1'b0; end
        check("bvalid_held", {63'b0, ok}, 64'd1);
        @(posedge ap_clk); #1;
        bready = 1'b1;
        @(negedge ap_clk);
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        check("bvalid_dropped", {63'b0, bvalid}, 64'd0);
        axi_read(6'h24, 32'h0);
        axi_read(6'h10, 32'h1234CC78);

        repeat (5) @(posedge ap_clk);
        check("read_queue_drained", 64'(rq.size()), 64'd0);
        check("write_queue_drained", 64'(bq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
